// File: rtl/irq_driver.sv
// ---------------------------------------------------------------------------
// irq_driver
//   Edge-triggered interrupt collector with masking, a global disable and
//   fixed-priority one-hot delivery (highest index wins).
//
//   Each request line is edge-detected against its previous sample.  A rising
//   edge latches a pending bit.  Pending bits are retained while masked or
//   disabled.  The highest-index eligible pending bit is presented on
//   `interrupts` combinationally.  It is cleared on the clock edge that ends
//   its delivery cycle, unless a new edge on the same line arrives on that
//   same clock edge.
//
//   Optional feature macro: IRQ_DRIVER_SYNC_EN
//     When defined, every request line passes through a 2-flop synchronizer
//     before edge detection.  This adds exactly two cycles of latency.
//
// Parameters
//   N                  number of interrupt lines (bit N-1 = highest priority)
// Ports
//   clk                rising-edge clock
//   rst                asynchronous active-high reset
//   interrupt_signs    [N] raw level request lines
//   interrupt_mask     [N] 1 = line blocked, 0 = line enabled
//   interrupt_disable  1 = nothing is delivered (pending state is kept)
//   interrupts         [N] one-hot or zero delivered interrupt, combinational
// ---------------------------------------------------------------------------
module irq_driver #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] interrupt_signs,
  input  logic [N-1:0] interrupt_mask,
  input  logic         interrupt_disable,
  output logic [N-1:0] interrupts
);

  logic [N-1:0] sample_s;

  // Number of clock edges after reset release before edge detection is armed.
  // The edge detector only arms once prev holds a real sample of every line.
  // Without this, a line that is already high at reset release would be
  // seen as a rising edge.
`ifdef IRQ_DRIVER_SYNC_EN
  localparam logic [1:0] WARM_EDGES = 2'd3;

  logic [N-1:0] sync1_q, sync1_d;
  logic [N-1:0] sync2_q, sync2_d;

  // Synchronizer next-state: a plain two-stage shift.
  always_comb begin
    sync1_d = interrupt_signs;
    sync2_d = sync1_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sample_s = sync2_q;
`else
  localparam logic [1:0] WARM_EDGES = 2'd1;

  assign sample_s = interrupt_signs;
`endif

  logic [N-1:0] prev_q,    prev_d;
  logic [N-1:0] pending_q, pending_d;
  logic [1:0]   warm_q,    warm_d;
  logic         armed_s;
  logic [N-1:0] rise_s;
  logic [N-1:0] eligible_s;
  logic [N-1:0] irq_s;
  logic         found_s;

  // Edge detection, eligibility and pending-bit next state.
  always_comb begin
    prev_d  = sample_s;
    armed_s = (warm_q == WARM_EDGES);

    if (armed_s) begin
      warm_d = warm_q;
      rise_s = sample_s & ~prev_q;
    end else begin
      warm_d = warm_q + 2'd1;
      rise_s = '0;
    end

    if (interrupt_disable) begin
      eligible_s = '0;
    end else begin
      eligible_s = pending_q & ~interrupt_mask;
    end

    // The delivered bit is cleared first and new edges are OR-ed in after.
    // A fresh edge that coincides with delivery of the same line therefore
    // survives.
    pending_d = (pending_q & ~irq_s) | rise_s;
  end

  // Fixed-priority pick: the highest-index eligible bit wins.
  always_comb begin
    irq_s   = '0;
    found_s = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible_s[i] && !found_s) begin
        irq_s[i] = 1'b1;
        found_s  = 1'b1;
      end else begin
        irq_s[i] = 1'b0;
      end
    end
  end

  assign interrupts = irq_s;

  // State flops: previous sample, pending requests and the warm-up counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '0;
      pending_q <= '0;
      warm_q    <= 2'd0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      warm_q    <= warm_d;
    end
  end

endmodule

// File: tb/tb_irq_driver.sv
// ---------------------------------------------------------------------------
// tb_irq_driver
//   Self-checking bench for irq_driver (N = 3).  Three stimulus sources are
//   used:
//     - A directed vector table: per cycle, the inputs and the expected
//       `interrupts` value.  The table values are written for the default
//       build, with no synchronizer.
//     - Hand-written multi-cycle sequences: reset behaviour and a long hold.
//     - Randomized stimulus.
//   Every cycle is also compared against a reference model.  The model keeps
//   the raw samples seen since reset.  From them it derives requests as
//   0->1 transitions, using the configured synchronizer delay.  It then
//   applies the pending, priority and delivery rules.
// ---------------------------------------------------------------------------
module tb_irq_driver;

  localparam int N = 3;
`ifdef IRQ_DRIVER_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] interrupt_signs;
  logic [N-1:0] interrupt_mask;
  logic         interrupt_disable;
  logic [N-1:0] interrupts;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [N-1:0] raw_hist[$];
  logic [N-1:0] model_pending;

  irq_driver #(.N(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .interrupt_signs   (interrupt_signs),
    .interrupt_mask    (interrupt_mask),
    .interrupt_disable (interrupt_disable),
    .interrupts        (interrupts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] s;
    logic [N-1:0] m;
    logic         d;
    logic [N-1:0] e;
  } vec_t;

  vec_t tab[32];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: interrupts=%b expected=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Highest-index pending, unmasked line; nothing at all while disabled.
  function automatic logic [N-1:0] model_irq(input logic [N-1:0] m, input logic d);
    logic [N-1:0] r;
    r = '0;
    if (!d) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (model_pending[i] && !m[i] && r == '0) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Called on each clock edge taken while out of reset.
  task automatic model_edge(input logic [N-1:0] raw, input logic [N-1:0] delivered);
    int k;
    logic [N-1:0] req;
    raw_hist.push_back(raw);
    k   = raw_hist.size() - 1;
    req = '0;
    if (k >= D + 1) req = raw_hist[k-D] & ~raw_hist[k-D-1];
    model_pending = (model_pending & ~delivered) | req;
  endtask

  // One clock cycle: apply inputs, compare, then take the clock edge.
  task automatic cycle(input logic [N-1:0] s, input logic [N-1:0] m, input logic d,
                       input bit use_tab, input logic [N-1:0] texp, input string name);
    logic [N-1:0] exp;
    interrupt_signs   = s;
    interrupt_mask    = m;
    interrupt_disable = d;
    #1;
    exp = model_irq(m, d);
    check({name, "/model"}, interrupts, exp);
    if (use_tab) check(name, interrupts, texp);
    @(posedge clk);
    model_edge(s, exp);
    #1;
  endtask

  // Assert rst for one clock edge, keeping the current inputs.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("in_reset", interrupts, 3'b000);
    @(posedge clk);
    #1;
    check("in_reset_after_edge", interrupts, 3'b000);
    raw_hist.delete();
    model_pending = '0;
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rs, rm;
    logic         rd;

    // Directed table: priority, mask, disable, double pulse, coincident
    // edge and delivery, and a mask change taking effect in the same cycle.
    tab[0]  = '{3'b000, 3'b000, 1'b0, 3'b000};
    tab[1]  = '{3'b101, 3'b000, 1'b0, 3'b000};
    tab[2]  = '{3'b101, 3'b000, 1'b0, 3'b100};
    tab[3]  = '{3'b101, 3'b000, 1'b0, 3'b001};
    tab[4]  = '{3'b000, 3'b000, 1'b0, 3'b000};
    tab[5]  = '{3'b000, 3'b001, 1'b0, 3'b000};
    tab[6]  = '{3'b001, 3'b001, 1'b0, 3'b000};
    tab[7]  = '{3'b000, 3'b001, 1'b0, 3'b000};
    tab[8]  = '{3'b000, 3'b001, 1'b0, 3'b000};
    tab[9]  = '{3'b000, 3'b001, 1'b0, 3'b000};
    tab[10] = '{3'b000, 3'b001, 1'b0, 3'b000};
    tab[11] = '{3'b000, 3'b000, 1'b0, 3'b001};
    tab[12] = '{3'b000, 3'b000, 1'b0, 3'b000};
    tab[13] = '{3'b010, 3'b000, 1'b1, 3'b000};
    tab[14] = '{3'b000, 3'b000, 1'b1, 3'b000};
    tab[15] = '{3'b000, 3'b000, 1'b1, 3'b000};
    tab[16] = '{3'b000, 3'b000, 1'b0, 3'b010};
    tab[17] = '{3'b000, 3'b000, 1'b0, 3'b000};
    tab[18] = '{3'b001, 3'b000, 1'b0, 3'b000};
    tab[19] = '{3'b000, 3'b000, 1'b0, 3'b001};
    tab[20] = '{3'b001, 3'b000, 1'b0, 3'b000};
    tab[21] = '{3'b000, 3'b000, 1'b0, 3'b001};
    tab[22] = '{3'b000, 3'b000, 1'b0, 3'b000};
    tab[23] = '{3'b001, 3'b001, 1'b0, 3'b000};
    tab[24] = '{3'b000, 3'b001, 1'b0, 3'b000};
    tab[25] = '{3'b001, 3'b000, 1'b0, 3'b001};
    tab[26] = '{3'b001, 3'b000, 1'b0, 3'b001};
    tab[27] = '{3'b000, 3'b000, 1'b0, 3'b000};
    tab[28] = '{3'b110, 3'b000, 1'b0, 3'b000};
    tab[29] = '{3'b110, 3'b100, 1'b0, 3'b010};
    tab[30] = '{3'b000, 3'b000, 1'b0, 3'b100};
    tab[31] = '{3'b000, 3'b000, 1'b0, 3'b000};

    model_pending = '0;

    // Reset with lines 0 and 1 already high.  Releasing reset must not
    // produce a request for them.
    rst               = 1'b1;
    interrupt_signs   = 3'b011;
    interrupt_mask    = 3'b000;
    interrupt_disable = 1'b0;
    #2;
    check("reset_state", interrupts, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle(3'b011, 3'b000, 1'b0, 1'b1, 3'b000, "high_at_release");
    for (int i = 0; i < 2; i++) cycle(3'b000, 3'b000, 1'b0, 1'b1, 3'b000, "idle");

    for (int i = 0; i < 32; i++) begin
      cycle(tab[i].s, tab[i].m, tab[i].d, 1'b1, tab[i].e, $sformatf("tab%0d", i));
    end

    // One edge on line 0, then held high for 25 cycles: exactly one delivery.
    for (int i = 0; i < 25; i++) begin
      cycle(3'b001, 3'b000, 1'b0, 1'b1, (i == 1) ? 3'b001 : 3'b000, $sformatf("hold25_%0d", i));
    end
    cycle(3'b000, 3'b000, 1'b0, 1'b1, 3'b000, "hold25_end");

    // Pend line 2, then reset while the line is still high.
    cycle(3'b100, 3'b000, 1'b0, 1'b1, 3'b000, "rst_mid_raise");
    do_reset();
    for (int i = 0; i < 4; i++) cycle(3'b100, 3'b000, 1'b0, 1'b1, 3'b000, $sformatf("rst_mid_hold%0d", i));
    cycle(3'b000, 3'b000, 1'b0, 1'b1, 3'b000, "rst_mid_low");
    cycle(3'b100, 3'b000, 1'b0, 1'b1, 3'b000, "rst_mid_reraise");
    cycle(3'b100, 3'b000, 1'b0, 1'b1, 3'b100, "rst_mid_deliver");
    cycle(3'b100, 3'b000, 1'b0, 1'b1, 3'b000, "rst_mid_after");

    // Randomized stimulus, checked against the model only.  There is one
    // reset in the middle of the run.
    rs = 3'b000;
    rm = 3'b000;
    rd = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 2) == 0) rs[b] = ~rs[b];
      end
      if ($urandom_range(0, 3) == 0) rm = 3'($urandom_range(0, 7));
      rd = ($urandom_range(0, 7) == 0);
      if (i == 200) do_reset();
      cycle(rs, rm, rd, 1'b0, 3'b000, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_driver.md
IRQ_DRIVER -- requirements
Module: irq_driver

Interface
REQ-001 Parameter: N, 3, number of interrupt lines; bit N-1 has the highest priority.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: interrupt_signs  input  N  raw device request lines, level-driven, held arbitrarily long.
REQ-005 Port: interrupt_mask  input  N  per-line mask; 1 = line blocked, 0 = line enabled.
REQ-006 Port: interrupt_disable  input  1  global disable; 1 = no interrupt delivered.
REQ-007 Port: interrupts  output  N  one-hot (or zero) delivered interrupt for the current cycle.

Function
REQ-008 The block SHALL keep a register prev[N-1:0] holding the previous-cycle sampled value of each request line.
REQ-009 A request SHALL be an edge event: sample = 1 while prev = 0 on a rising clk edge.
REQ-010 Each request SHALL set pending[i] on that rising edge. A line held high for many cycles SHALL produce exactly one request.
REQ-011 eligible = pending & ~interrupt_mask, forced to all-zero while interrupt_disable = 1.
REQ-012 interrupts SHALL be combinational from eligible, with fixed priority. Only the highest-index eligible bit is driven; all others are 0.
REQ-013 On a rising edge where interrupts[i] = 1, pending[i] SHALL clear (one-cycle delivery).
REQ-014 If a new edge on line i coincides with delivery of line i, pending[i] SHALL remain set.
REQ-015 Masked or disabled pending bits SHALL be retained, not dropped. They are delivered once unmasked or re-enabled, still subject to priority.
REQ-016 Lower-priority pending bits SHALL wait while a higher one is delivered. They are delivered in later cycles, one per cycle, highest first.
REQ-017 Latency without the synchronizer: the edge is detected at clk edge E. interrupts is asserted in the cycle following E, provided the line is eligible.
REQ-018 Changes to interrupt_mask and interrupt_disable SHALL affect interrupts combinationally in the same cycle.

Reset
REQ-019 rst = 1 SHALL asynchronously clear pending, prev and any synchronizer flops to 0.
REQ-020 interrupts SHALL read 0 from reset assertion until the first post-reset request.
REQ-021 A line already high when rst deasserts SHALL NOT generate a request, because prev captures it on the first edge.
REQ-022 Reset mid-operation SHALL discard all pending requests.

Configuration
REQ-023 Macro IRQ_DRIVER_SYNC_EN: when defined, interrupt_signs SHALL pass through a 2-flop synchronizer per line before edge detection.
REQ-024 With IRQ_DRIVER_SYNC_EN, delivery latency SHALL increase by exactly 2 cycles.
REQ-025 Without IRQ_DRIVER_SYNC_EN, interrupt_signs SHALL be sampled directly and REQ-017 latency applies.

Verification
REQ-026 Scenario: mask = 000, disable = 0; raise signs = 001 and hold 25 cycles. interrupts = 001 for exactly one cycle, then 000 throughout.
REQ-027 Scenario: signs 000→101 in one cycle. interrupts = 100 for one cycle, then 001 for one cycle, then 000.
REQ-028 Scenario: mask = 001; pulse line 0 for one cycle. interrupts stays 000. Clear mask 5 cycles later: interrupts = 001 for one cycle.
REQ-029 Scenario: disable = 1; pulse line 1. interrupts stays 000. Drop disable: interrupts = 010 for one cycle.
REQ-030 Scenario: pend line 2, then assert rst for one cycle while the line is still high. interrupts = 000 afterwards; no request until the line toggles low then high.
REQ-031 Scenario: pulse line 0 twice, 2 cycles apart, with mask = 000. Two separate single-cycle 001 deliveries.
